// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch stage:
//               buffer occupancy encoding and datapath widths.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam logic [PC_W-1:0] PC_INC = 32'd4;

    // Occupancy of the two-entry fetch buffer
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fetch_state_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer
// Description : Two-entry FIFO of {pc, instr} pairs between instruction memory
//               and decode. Head entry drives the outputs directly; flush
//               empties the buffer and overrides push/pop.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [PC_W-1:0]    push_pc,
    input  logic [INSTR_W-1:0] push_instr,
    output fetch_state_t       state,
    output logic               head_valid,
    output logic [PC_W-1:0]    head_pc,
    output logic [INSTR_W-1:0] head_instr
);

    fetch_state_t       r_state;
    logic               r_head;
    logic [PC_W-1:0]    r_pc    [2];
    logic [INSTR_W-1:0] r_instr [2];

    logic w_tail;
    logic w_push;
    logic w_pop;

    // With one entry the free slot is the one after head; when empty, or
    // when full and the head is leaving this cycle, the head slot is reused.
    assign w_tail = (r_state == ONE) ? ~r_head : r_head;
    assign w_push = push && !flush;
    assign w_pop  = pop && !flush && (r_state != EMPTY);

    // Occupancy FSM, head pointer and entry storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= EMPTY;
            r_head     <= 1'b0;
            r_pc[0]    <= '0;
            r_pc[1]    <= '0;
            r_instr[0] <= '0;
            r_instr[1] <= '0;
        end else if (flush) begin
            // Stored data is left in place; only occupancy is cleared
            r_state <= EMPTY;
        end else begin
            if (w_push) begin
                r_pc[w_tail]    <= push_pc;
                r_instr[w_tail] <= push_instr;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            case (r_state)
                EMPTY: if (w_push)            r_state <= ONE;
                ONE: begin
                    if (w_push && !w_pop)      r_state <= FULL;
                    else if (w_pop && !w_push) r_state <= EMPTY;
                end
                FULL:  if (w_pop && !w_push)  r_state <= ONE;
                default:                      r_state <= EMPTY;
            endcase
        end
    end

    assign state      = r_state;
    assign head_valid = (r_state != EMPTY);
    assign head_pc    = r_pc[r_head];
    assign head_instr = r_instr[r_head];

endmodule : fetch_buffer
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Owns the PC, presents it to the
//               combinational instruction memory, buffers returned words in
//               a two-entry FIFO and redirects/flushes on taken branches.
//               Optional performance counters enabled by FETCH_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [PC_W-1:0]    imem_pc,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_addr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_redirect_cnt
`endif
);

    logic [PC_W-1:0] r_pc;
    fetch_state_t    w_state;
    logic            w_valid;
    logic            w_pop;
    logic            w_push;
    logic [PC_W-1:0] w_target;

    // A redirect suppresses both push and pop for that cycle
    assign w_pop    = w_valid && out_ready && !branch_taken;
    assign w_push   = !branch_taken && ((w_state != FULL) || w_pop);
    assign w_target = branch_addr & ~32'h0000_0003;

    // Program counter: redirect wins, otherwise advance on each fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (branch_taken) begin
            r_pc <= w_target;
        end else if (w_push) begin
            r_pc <= r_pc + PC_INC;
        end
    end

    fetch_buffer u_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (w_push),
        .pop        (w_pop),
        .flush      (branch_taken),
        .push_pc    (r_pc),
        .push_instr (imem_instr),
        .state      (w_state),
        .head_valid (w_valid),
        .head_pc    (out_pc),
        .head_instr (out_instr)
    );

    assign imem_pc   = r_pc;
    assign out_valid = w_valid;

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_redirect_cnt;

    // Count fetches and redirects; both wrap naturally at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_cnt    <= '0;
            r_redirect_cnt <= '0;
        end else begin
            if (w_push)       r_fetch_cnt    <= r_fetch_cnt + 32'd1;
            if (branch_taken) r_redirect_cnt <= r_redirect_cnt + 32'd1;
        end
    end

    assign perf_fetch_cnt    = r_fetch_cnt;
    assign perf_redirect_cnt = r_redirect_cnt;
`endif

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit using a table of directed
//               per-cycle vectors plus hand sequences for reset corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    logic [31:0] imem_pc2;
    logic [31:0] imem_instr2;
    logic        out_valid2;
    logic [31:0] out_pc2;
    logic [31:0] out_instr2;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_redirect_cnt;
    logic [31:0] perf_fetch_cnt2;
    logic [31:0] perf_redirect_cnt2;
`endif

    int n_cmp;
    int n_bad;

    // Instruction memory contents
    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0)      return 32'h0022_0000;
        else if (a == 32'h4) return 32'h0064_0000;
        else                 return ~a;
    endfunction

    assign imem_instr  = mem(imem_pc);
    assign imem_instr2 = mem(imem_pc2);

    fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_pc      (imem_pc),
        .imem_instr   (imem_instr),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_instr    (out_instr)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt    (perf_fetch_cnt),
        .perf_redirect_cnt (perf_redirect_cnt)
`endif
    );

    // Second instance exercises PC wrap from the top of the address space
    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_pc      (imem_pc2),
        .imem_instr   (imem_instr2),
        .branch_taken (1'b0),
        .branch_addr  (32'h0),
        .out_valid    (out_valid2),
        .out_ready    (1'b1),
        .out_pc       (out_pc2),
        .out_instr    (out_instr2)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt    (perf_fetch_cnt2),
        .perf_redirect_cnt (perf_redirect_cnt2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ready;
        logic        br;
        logic [31:0] baddr;
        logic        exp_valid;
        logic        chk_data;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic [31:0] exp_imem_pc;
    } vec_t;

    vec_t vecs[17];

    initial begin
        // Steady flow from reset
        vecs[0]  = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h00, 32'h0022_0000, 32'h04};
        vecs[1]  = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h04, 32'h0064_0000, 32'h08};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h08, ~32'h08,       32'h0C};
        // Backpressure: fill then stall
        vecs[3]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h08, ~32'h08,       32'h10};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h08, ~32'h08,       32'h10};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h08, ~32'h08,       32'h10};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h08, ~32'h08,       32'h10};
        // Release: pop and push on the same edge while full
        vecs[7]  = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0C, ~32'h0C,       32'h14};
        vecs[8]  = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h10, ~32'h10,       32'h18};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h10, ~32'h10,       32'h18};
        // Redirect while full
        vecs[10] = '{1'b0, 1'b1, 32'h30, 1'b0, 1'b0, 32'h0,  32'h0,         32'h30};
        vecs[11] = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h30, ~32'h30,       32'h34};
        // Unaligned target, redirect coincident with ready
        vecs[12] = '{1'b1, 1'b1, 32'h13, 1'b0, 1'b0, 32'h0,  32'h0,         32'h10};
        vecs[13] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h10, ~32'h10,       32'h14};
        vecs[14] = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h14, ~32'h14,       32'h18};
        // Fill to FULL before asynchronous reset
        vecs[15] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h14, ~32'h14,       32'h1C};
        vecs[16] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h14, ~32'h14,       32'h1C};

        n_cmp = 0;
        n_bad = 0;
        rst_n        = 1'b0;
        out_ready    = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'h0;

        repeat (2) @(negedge clk);
        check("reset_imem_pc",   imem_pc,   32'h0);
        check("reset_valid",     {31'b0, out_valid}, 32'h0);
        check("reset_out_pc",    out_pc,    32'h0);
        check("reset_out_instr", out_instr, 32'h0);
        check("wrap_reset_pc",   imem_pc2,  32'hFFFF_FFFC);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            out_ready    = vecs[i].ready;
            branch_taken = vecs[i].br;
            branch_addr  = vecs[i].baddr;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].exp_valid});
            check($sformatf("v%0d_imem_pc", i), imem_pc, vecs[i].exp_imem_pc);
            if (vecs[i].chk_data) begin
                check($sformatf("v%0d_out_pc", i), out_pc, vecs[i].exp_pc);
                check($sformatf("v%0d_out_instr", i), out_instr, vecs[i].exp_instr);
            end
            if (i == 0) begin
                check("wrap_imem_pc",   imem_pc2,   32'h0);
                check("wrap_out_pc",    out_pc2,    32'hFFFF_FFFC);
                check("wrap_out_instr", out_instr2, 32'h0000_0003);
            end
            @(negedge clk);
        end

`ifdef FETCH_PERF_EN
        check("perf_fetch",    perf_fetch_cnt,    32'd10);
        check("perf_redirect", perf_redirect_cnt, 32'd2);
`endif

        // Asynchronous reset away from any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_valid",     {31'b0, out_valid}, 32'h0);
        check("areset_imem_pc",   imem_pc,   32'h0);
        check("areset_out_pc",    out_pc,    32'h0);
        check("areset_out_instr", out_instr, 32'h0);
`ifdef FETCH_PERF_EN
        check("areset_perf_fetch",    perf_fetch_cnt,    32'h0);
        check("areset_perf_redirect", perf_redirect_cnt, 32'h0);
`endif

        // Redirect on the first edge after release still lands on target
        @(negedge clk);
        rst_n        = 1'b1;
        branch_taken = 1'b1;
        branch_addr  = 32'h0000_0042;
        out_ready    = 1'b1;
        @(posedge clk);
        #1;
        check("rel_redirect_valid", {31'b0, out_valid}, 32'h0);
        check("rel_redirect_pc",    imem_pc, 32'h40);
        @(negedge clk);
        branch_taken = 1'b0;
        @(posedge clk);
        #1;
        check("rel_target_valid", {31'b0, out_valid}, 32'h1);
        check("rel_target_pc",    out_pc,    32'h40);
        check("rel_target_instr", out_instr, ~32'h40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the combinational instruction memory. Holds the program counter, presents it to the memory, captures each returned word with its PC into a 2-entry buffer, and hands them to decode over a valid/ready handshake. Taken branches redirect the PC and flush everything already fetched.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- imem_pc  out  32  address to instruction memory; equals the PC register
- imem_instr  in  32  word returned combinationally for imem_pc in the same cycle
- branch_taken  in  1  redirect request from execute, sampled at rising edge
- branch_addr  in  32  redirect target; bits [1:0] ignored, treated as 0
- out_valid  out  1  buffer head holds a valid instruction
- out_ready  in  1  decode accepts head this cycle
- out_pc  out  32  PC of head instruction
- out_instr  out  32  head instruction word
- perf_fetch_cnt  out  32  present only with FETCH_PERF_EN
- perf_redirect_cnt  out  32  present only with FETCH_PERF_EN

## Operation
- State = buffer occupancy: EMPTY (0), ONE (1), FULL (2).
- pop = out_valid && out_ready.
- push = !branch_taken && (state != FULL || pop).
- On push: write {imem_pc, imem_instr} at tail; PC <= PC + 4 (32-bit modulo, 0xFFFF_FFFC wraps to 0).
- No push: PC holds.
- branch_taken (highest priority): state <= EMPTY, all entries discarded, PC <= {branch_addr[31:2], 2'b00}; no push or pop that cycle, out_ready ignored.
- Transitions: EMPTY→ONE on push; ONE→FULL on push&&!pop; ONE→EMPTY on pop&&!push; FULL→ONE on pop&&!push; push&&pop keeps state; any state→EMPTY on branch_taken.
- Entries pop in fetch order; out_pc/out_instr driven from head entry directly (no extra register).
- out_pc/out_instr hold their last value when out_valid=0; decode must not use them.
- Reset (asynchronous, any time, including mid-redirect): PC <= RESET_PC, state <= EMPTY, both entries <= 0; hence imem_pc=RESET_PC, out_valid=0, out_pc=0, out_instr=0, perf counters=0.

## Timing
- Fetch-to-output latency: 1 cycle (word for imem_pc at edge N visible on out_* after edge N).
- Steady state with out_ready=1: one instruction per cycle, no bubbles.
- Backpressure: with out_ready=0 from EMPTY, two fetches complete, then PC stalls; releasing out_ready resumes one-per-cycle with no gap (push on same edge as pop when FULL).
- Redirect penalty: edge with branch_taken → out_valid=0 next cycle; target instruction valid the cycle after.
- First instruction after reset release: valid after first rising edge.

## Configuration
- FETCH_PERF_EN defined: perf_fetch_cnt increments on every push; perf_redirect_cnt increments on every branch_taken edge; both 32-bit, wrap at 2^32, cleared by reset.
- Undefined: both ports and counters absent; functional behaviour otherwise identical.

## Structure
- Shared package fetch_pkg: state enum (EMPTY/ONE/FULL), INSTR_W=32, PC_W=32, PC_INC=4.
- Sub-module fetch_buffer: 2-entry FIFO of {pc, instr} with push/pop/flush, occupancy state, head outputs; fetch_unit keeps PC register, push/redirect logic, perf counters.

## Test plan
- Reset release, out_ready=1, memory word 0x0022_0000 at 0, 0x0064_0000 at 4 → out_pc 0, 4, 8… on consecutive cycles, out_instr 0x0022_0000 then 0x0064_0000.
- out_ready=0 after reset for 4 cycles → imem_pc stops at 8, out_pc stays 0, state FULL; out_ready=1 → out_pc 0, 4, 8 back-to-back.
- branch_taken=1, branch_addr=0x18 while FULL → next cycle out_valid=0, imem_pc=0x18; following cycle out_pc=0x18, out_instr=word at 0x18.
- branch_addr=0x13 → imem_pc=0x10; branch_taken coincident with out_ready=1 → no pop counted, buffer empty.
- RESET_PC=0xFFFF_FFFC → after first push imem_pc=0x0000_0000.
- rst_n low mid-run (FULL, PC=0x20) without clock edge → out_valid=0, imem_pc=RESET_PC immediately; with FETCH_PERF_EN both counters read 0.
